// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with PWM dimming, blink and
// double-buffered digit contents that only change at frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 17,
    parameter int BRIGHT_BITS  = 4,
    parameter int BLINK_BITS   = 25
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   hex_in,
    input  logic [7*NUM_DIGITS-1:0]   raw_in,
    input  logic [NUM_DIGITS-1:0]     raw_sel,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_sync
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIGITS - 1);

    logic [REFRESH_BITS-1:0]       presc;
    logic [IDXW-1:0]               idx;
    logic [BLINK_BITS-1:0]         blink_cnt;

    logic [NUM_DIGITS-1:0][3:0]    act_hex, pnd_hex;
    logic [NUM_DIGITS-1:0][6:0]    act_raw, pnd_raw;
    logic [NUM_DIGITS-1:0]         act_raw_sel, pnd_raw_sel;
    logic [NUM_DIGITS-1:0]         act_dp, pnd_dp;
    logic [NUM_DIGITS-1:0]         act_blank, pnd_blank;
    logic [NUM_DIGITS-1:0]         act_blink, pnd_blink;
    logic                          pnd_valid;

    logic                          wrap;
    logic                          commit;
    logic [BRIGHT_BITS-1:0]        duty;
    logic                          pwm_on;
    logic                          dark;
    logic [6:0]                    seg_next;
    logic                          dp_next;
    logic [NUM_DIGITS-1:0]         an_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign wrap   = &presc;
    assign commit = wrap && (idx == LAST_IDX);
    assign duty   = presc[REFRESH_BITS-1 -: BRIGHT_BITS];
    assign pwm_on = (duty < brightness) || (&brightness);
    assign dark   = act_blank[idx] | (act_blink[idx] & blink_cnt[BLINK_BITS-1]);

    always_comb begin
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        an_next  = '1;
        if (!dark) begin
            seg_next = act_raw_sel[idx] ? act_raw[idx] : hex_decode(act_hex[idx]);
            dp_next  = ~act_dp[idx];
        end
        if (pwm_on)
            an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
        end else begin
            presc     <= presc + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (wrap)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // A load landing on the commit cycle bypasses pending so it shows this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_hex     <= '0;
            act_raw     <= '0;
            act_raw_sel <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            act_blink   <= '0;
            pnd_hex     <= '0;
            pnd_raw     <= '0;
            pnd_raw_sel <= '0;
            pnd_dp      <= '0;
            pnd_blank   <= '1;
            pnd_blink   <= '0;
            pnd_valid   <= 1'b0;
        end else begin
            if (load) begin
                pnd_hex     <= hex_in;
                pnd_raw     <= raw_in;
                pnd_raw_sel <= raw_sel;
                pnd_dp      <= dp_in;
                pnd_blank   <= blank_in;
                pnd_blink   <= blink_en;
            end
            if (commit) begin
                pnd_valid <= 1'b0;
                if (load) begin
                    act_hex     <= hex_in;
                    act_raw     <= raw_in;
                    act_raw_sel <= raw_sel;
                    act_dp      <= dp_in;
                    act_blank   <= blank_in;
                    act_blink   <= blink_en;
                end else if (pnd_valid) begin
                    act_hex     <= pnd_hex;
                    act_raw     <= pnd_raw;
                    act_raw_sel <= pnd_raw_sel;
                    act_dp      <= pnd_dp;
                    act_blank   <= pnd_blank;
                    act_blink   <= pnd_blink;
                end
            end else if (load) begin
                pnd_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= '1;
            frame_sync <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
            frame_sync <= commit;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: per-cycle scoreboard from a time-indexed model,
// a table of single-digit vectors, and hand-written multi-cycle sequences.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [27:0] raw_in = '0;
    logic [3:0]  raw_sel = '0, dp_in = '0, blank_in = '0, blink_en = '0;
    logic [1:0]  brightness = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_sync;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4), .REFRESH_BITS(4), .BRIGHT_BITS(2), .BLINK_BITS(6)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .raw_in(raw_in),
        .raw_sel(raw_sel), .dp_in(dp_in), .blank_in(blank_in), .blink_en(blink_en),
        .brightness(brightness), .seg(seg), .dp(dp), .an(an), .frame_sync(frame_sync)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } exp_t;
    exp_t sbq[$];

    // Model state indexed by m_t = clock edges since reset released.
    logic [15:0] m_hex, p_hex;
    logic [27:0] m_raw, p_raw;
    logic [3:0]  m_rs, p_rs, m_dp, p_dp, m_blank, p_blank, m_blink, p_blink;
    logic        m_pf;
    int          m_t = 0;

    initial begin : model
        exp_t e;
        int   presc, idx, duty;
        bit   bmsb, on, commit;
        forever begin
            @(posedge clk);
            if (reset) begin
                e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.fs = 1'b0;
                sbq.push_back(e);
                m_hex = '0; m_raw = '0; m_rs = '0; m_dp = '0; m_blank = 4'hF; m_blink = '0;
                p_hex = '0; p_raw = '0; p_rs = '0; p_dp = '0; p_blank = 4'hF; p_blink = '0;
                m_pf = 1'b0;
                m_t = 0;
            end else begin
                presc = m_t % 16;
                idx   = (m_t / 16) % 4;
                bmsb  = (m_t % 64) >= 32;
                duty  = presc / 4;
                on    = (duty < int'(brightness)) || (brightness == 2'd3);
                e.an  = 4'hF;
                if (on) e.an[idx] = 1'b0;
                if (m_blank[idx] || (m_blink[idx] && bmsb)) begin
                    e.seg = 7'h7F; e.dp = 1'b1;
                end else begin
                    e.seg = m_rs[idx] ? m_raw[idx*7 +: 7] : dec(m_hex[idx*4 +: 4]);
                    e.dp  = ~m_dp[idx];
                end
                e.fs = ((m_t + 1) % 64) == 0;
                sbq.push_back(e);
                commit = (m_t % 64) == 63;
                if (load) begin
                    p_hex = hex_in; p_raw = raw_in; p_rs = raw_sel;
                    p_dp = dp_in; p_blank = blank_in; p_blink = blink_en;
                    m_pf = 1'b1;
                end
                if (commit && m_pf) begin
                    m_hex = p_hex; m_raw = p_raw; m_rs = p_rs;
                    m_dp = p_dp; m_blank = p_blank; m_blink = p_blink;
                    m_pf = 1'b0;
                end
                m_t++;
            end
        end
    end

    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("sb t=%0d {seg,dp,an,fs}", m_t),
                    {seg, dp, an, frame_sync}, {e.seg, e.dp, e.an, e.fs});
            end
        end
    end

    task automatic do_load(input logic [15:0] h, input logic [27:0] r, input logic [3:0] rs,
                           input logic [3:0] d, input logic [3:0] b, input logic [3:0] bl);
        @(negedge clk);
        hex_in = h; raw_in = r; raw_sel = rs; dp_in = d; blank_in = b; blink_en = bl;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_sync !== 1'b1 && n < 300);
        chk("frame_sync_wait", frame_sync, 1'b1);
    endtask

    typedef struct {
        logic [15:0] hex;
        logic [27:0] raw;
        logic [3:0]  rs, dpv, blank, blink;
        logic [1:0]  bright;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  e_an;
    } vec_t;
    vec_t vt [8];

    initial begin : stim
        int cnt, n;
        vt[0] = '{16'h1A2F, 28'h0,        4'h0, 4'h0, 4'h0, 4'h0, 2'd3, 7'b0001110, 1'b1, 4'b1110};
        vt[1] = '{16'h0000, 28'h000002B,  4'h1, 4'h2, 4'h0, 4'h0, 2'd3, 7'b0101011, 1'b1, 4'b1110};
        vt[2] = '{16'h0008, 28'h0,        4'h0, 4'h0, 4'h1, 4'h0, 2'd3, 7'b1111111, 1'b1, 4'b1110};
        vt[3] = '{16'h000B, 28'h0,        4'h0, 4'h1, 4'h0, 4'h0, 2'd3, 7'b0000011, 1'b0, 4'b1110};
        vt[4] = '{16'h5436, 28'h0,        4'h0, 4'h0, 4'h0, 4'h1, 2'd3, 7'b0000010, 1'b1, 4'b1110};
        vt[5] = '{16'hC00D, 28'h0,        4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 7'b0100001, 1'b1, 4'b1110};
        vt[6] = '{16'h0007, 28'h0,        4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 7'b1111000, 1'b1, 4'b1111};
        vt[7] = '{16'hE009, 28'h0000055,  4'h0, 4'h0, 4'h0, 4'h0, 2'd3, 7'b0010000, 1'b1, 4'b1110};

        repeat (3) @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_fs", frame_sync, 1'b0);
        reset = 1'b0;

        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (frame_sync) cnt++;
        end
        chk("fs_count_200", cnt, 3);

        for (int i = 0; i < 8; i++) begin
            brightness = vt[i].bright;
            do_load(vt[i].hex, vt[i].raw, vt[i].rs, vt[i].dpv, vt[i].blank, vt[i].blink);
            wait_fs();
            @(negedge clk);
            chk($sformatf("vec%0d_seg", i), seg, vt[i].e_seg);
            chk($sformatf("vec%0d_dp", i), dp, vt[i].e_dp);
            chk($sformatf("vec%0d_an", i), an, vt[i].e_an);
        end

        do_load(16'h1A2F, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        brightness = 2'd1;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (an != 4'hF) cnt++;
        end
        chk("pwm_b1_on_cycles", cnt, 16);
        brightness = 2'd0;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (an != 4'hF) cnt++;
        end
        chk("pwm_b0_on_cycles", cnt, 0);

        brightness = 2'd3;
        wait_fs();
        do_load(16'h1111, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (5) @(negedge clk);
        do_load(16'h2222, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        wait_fs();
        @(negedge clk);
        chk("two_loads_last_wins", seg, 7'b0100100);

        do_load(16'h5555, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        n = 0;
        while ((m_t % 64) != 63 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("commit_cycle_reached", m_t % 64, 63);
        hex_in = 16'h3333;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("commit_load_fs", frame_sync, 1'b1);
        @(negedge clk);
        chk("commit_load_same_frame", seg, 7'b0110000);

        wait_fs();
        repeat (20) @(negedge clk);
        do_load(16'h6666, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_an", an, 4'hF);
        chk("midreset_seg", seg, 7'h7F);
        chk("midreset_dp", dp, 1'b1);
        chk("midreset_fs", frame_sync, 1'b0);
        reset = 1'b0;
        wait_fs();
        @(negedge clk);
        chk("midreset_pending_discarded", seg, 7'h7F);
        chk("midreset_an_pwm", an, 4'b1110);

        do_load(16'h4321, 28'h0, 4'h0, 4'h0, 4'h0, 4'b0101);
        wait_fs();
        @(negedge clk);
        chk("blink_d0_phase0_lit", seg, 7'b1111001);
        repeat (32) @(negedge clk);
        chk("blink_d2_phase1_dark", seg, 7'h7F);
        chk("blink_d2_an", an, 4'b1011);
        repeat (64) @(negedge clk);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
